// File: rtl/arc4_pkg.sv
// Shared widths, character bounds, state encodings and a helper for the arc4 key search.
package arc4_pkg;

  localparam int unsigned KEY_W  = 24;
  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned IDX_W  = ADDR_W + 1;

  localparam logic [DATA_W-1:0] ASCII_LO = 8'h20;
  localparam logic [DATA_W-1:0] ASCII_HI = 8'h7E;

  typedef enum logic [2:0] {
    IDLE,
    START,
    BUSY,
    RUN,
    LEN,
    SCAN,
    PASS,
    FAIL
  } ks_state_t;

  typedef enum logic [2:0] {
    SC_IDLE,
    SC_LEN0,
    SC_LEN1,
    SC_ADDR,
    SC_CHK
  } sc_state_t;

  function automatic logic is_printable(input logic [DATA_W-1:0] c,
                                        input logic [DATA_W-1:0] lo,
                                        input logic [DATA_W-1:0] hi);
    return (c >= lo) && (c <= hi);
  endfunction

endpackage

// File: rtl/pt_scan.sv
// Walks the length-prefixed plaintext memory and reports whether every character is in range.
// Memory is synchronous: data for an address appears the cycle after the address is presented.
module pt_scan
  import arc4_pkg::*;
#(
  parameter logic [DATA_W-1:0] CH_LO = ASCII_LO,
  parameter logic [DATA_W-1:0] CH_HI = ASCII_HI
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  output logic              o_done,
  output logic              o_pass,
  output logic [ADDR_W-1:0] o_pt_addr,
  input  logic [DATA_W-1:0] i_pt_rddata
);

  sc_state_t         r_state, w_state_nxt;
  logic [DATA_W-1:0] r_len, w_len_nxt;
  logic [IDX_W-1:0]  r_idx, w_idx_nxt;
  logic [ADDR_W-1:0] r_addr, w_addr_nxt;
  logic              r_done, w_done_nxt;
  logic              r_pass, w_pass_nxt;

  assign o_done    = r_done;
  assign o_pass    = r_pass;
  assign o_pt_addr = r_addr;

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= SC_IDLE;
      r_len   <= '0;
      r_idx   <= '0;
      r_addr  <= '0;
      r_done  <= 1'b0;
      r_pass  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_len   <= w_len_nxt;
      r_idx   <= w_idx_nxt;
      r_addr  <= w_addr_nxt;
      r_done  <= w_done_nxt;
      r_pass  <= w_pass_nxt;
    end
  end

  // Length fetch then two cycles per character: present address, then check the returned byte
  always_comb begin
    w_state_nxt = r_state;
    w_len_nxt   = r_len;
    w_idx_nxt   = r_idx;
    w_addr_nxt  = r_addr;
    w_done_nxt  = 1'b0;
    w_pass_nxt  = r_pass;
    case (r_state)
      SC_IDLE: begin
        if (i_start) begin
          w_addr_nxt  = '0;
          w_state_nxt = SC_LEN0;
        end
      end
      SC_LEN0: w_state_nxt = SC_LEN1;
      SC_LEN1: begin
        w_len_nxt = i_pt_rddata;
        w_idx_nxt = IDX_W'(1);
        if (i_pt_rddata == '0) begin
          // An empty message never counts as a valid decryption
          w_done_nxt  = 1'b1;
          w_pass_nxt  = 1'b0;
          w_state_nxt = SC_IDLE;
        end else begin
          w_addr_nxt  = ADDR_W'(1);
          w_state_nxt = SC_ADDR;
        end
      end
      SC_ADDR: w_state_nxt = SC_CHK;
      SC_CHK: begin
        if (!is_printable(i_pt_rddata, CH_LO, CH_HI)) begin
          w_done_nxt  = 1'b1;
          w_pass_nxt  = 1'b0;
          w_addr_nxt  = '0;
          w_state_nxt = SC_IDLE;
        end else if (r_idx == IDX_W'(r_len)) begin
          w_done_nxt  = 1'b1;
          w_pass_nxt  = 1'b1;
          w_addr_nxt  = '0;
          w_state_nxt = SC_IDLE;
        end else begin
          w_idx_nxt   = r_idx + IDX_W'(1);
          w_addr_nxt  = ADDR_W'(r_idx + IDX_W'(1));
          w_state_nxt = SC_ADDR;
        end
      end
      default: w_state_nxt = SC_IDLE;
    endcase
  end

endmodule

// File: rtl/arc4_key_search.sv
// Brute-force key search: starts arc4 per trial key and accepts the first key whose
// plaintext is entirely printable. Owns the key loop and the arc4 en/rdy handshake.
module arc4_key_search
  import arc4_pkg::*;
#(
  parameter logic [KEY_W-1:0]  KEY_START = 24'h000000,
  parameter logic [KEY_W-1:0]  KEY_LAST  = 24'hFFFFFF,
  parameter logic [DATA_W-1:0] CH_LO     = ASCII_LO,
  parameter logic [DATA_W-1:0] CH_HI     = ASCII_HI
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  output logic              rdy,
  output logic [KEY_W-1:0]  key,
  output logic              key_valid,
  output logic              a4_en,
  input  logic              a4_rdy,
  output logic [KEY_W-1:0]  a4_key,
  output logic [ADDR_W-1:0] pt_addr,
  input  logic [DATA_W-1:0] pt_rddata
);

  ks_state_t        r_state, w_state_nxt;
  logic [KEY_W-1:0] r_trial, w_trial_nxt;
  logic [KEY_W-1:0] r_key, w_key_nxt;
  logic             r_key_valid, w_key_valid_nxt;
  logic             r_a4_en, w_a4_en_nxt;
  logic             r_rdy, w_rdy_nxt;
  logic             r_scan_start, w_scan_start_nxt;
  logic             w_scan_done;
  logic             w_scan_pass;
  logic [ADDR_W-1:0] w_pt_addr;

  assign rdy       = r_rdy;
  assign key       = r_key;
  assign key_valid = r_key_valid;
  assign a4_en     = r_a4_en;
  // The trial register only changes in IDLE/FAIL, so it stays stable while arc4 runs
  assign a4_key    = r_trial;
  assign pt_addr   = w_pt_addr;

  pt_scan #(
    .CH_LO(CH_LO),
    .CH_HI(CH_HI)
  ) u_pt_scan (
    .clk        (clk),
    .rst        (rst),
    .i_start    (r_scan_start),
    .o_done     (w_scan_done),
    .o_pass     (w_scan_pass),
    .o_pt_addr  (w_pt_addr),
    .i_pt_rddata(pt_rddata)
  );

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_trial      <= KEY_START;
      r_key        <= '0;
      r_key_valid  <= 1'b0;
      r_a4_en      <= 1'b0;
      r_rdy        <= 1'b1;
      r_scan_start <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_trial      <= w_trial_nxt;
      r_key        <= w_key_nxt;
      r_key_valid  <= w_key_valid_nxt;
      r_a4_en      <= w_a4_en_nxt;
      r_rdy        <= w_rdy_nxt;
      r_scan_start <= w_scan_start_nxt;
    end
  end

  // Key loop: start arc4, wait for busy then ready, scan plaintext, advance or finish
  always_comb begin
    w_state_nxt      = r_state;
    w_trial_nxt      = r_trial;
    w_key_nxt        = r_key;
    w_key_valid_nxt  = r_key_valid;
    w_a4_en_nxt      = 1'b0;
    w_scan_start_nxt = 1'b0;
    case (r_state)
      IDLE: begin
        if (en) begin
          w_trial_nxt     = KEY_START;
          w_key_nxt       = '0;
          w_key_valid_nxt = 1'b0;
          w_state_nxt     = START;
        end
      end
      START: begin
        // Never pulse into a busy arc4 (it is not reset with this block)
        if (a4_rdy) begin
          w_a4_en_nxt = 1'b1;
          w_state_nxt = BUSY;
        end
      end
      BUSY: begin
        // Ready seen right after the pulse may be stale; wait for arc4 to drop it
        if (!a4_rdy) w_state_nxt = RUN;
      end
      RUN: begin
        if (a4_rdy) begin
          w_scan_start_nxt = 1'b1;
          w_state_nxt      = LEN;
        end
      end
      LEN: w_state_nxt = SCAN;
      SCAN: begin
        if (w_scan_done) w_state_nxt = w_scan_pass ? PASS : FAIL;
      end
      PASS: begin
        w_key_nxt       = r_trial;
        w_key_valid_nxt = 1'b1;
        w_state_nxt     = IDLE;
      end
      FAIL: begin
        // Compare before incrementing so the trial never wraps past KEY_LAST
        if (r_trial == KEY_LAST) begin
          w_key_valid_nxt = 1'b0;
          w_state_nxt     = IDLE;
        end else begin
          w_trial_nxt = r_trial + KEY_W'(1);
          w_state_nxt = START;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
    w_rdy_nxt = (w_state_nxt == IDLE);
  end

endmodule

// File: tb/tb_arc4_key_search.sv
// Bench for arc4_key_search: arc4 modelled as a 40-cycle busy responder that writes scripted
// plaintext into a 256x8 synchronous RAM. Trial keys are scoreboarded against a4_en pulses.
`timescale 1ns/1ps
module tb_arc4_key_search;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en  = 1'b0;
  logic en2 = 1'b0;
  logic sel = 1'b0;

  always #5 clk = ~clk;

  logic        rdy1, kv1, a4_en1;
  logic [23:0] key1, a4_key1;
  logic [7:0]  pt_addr1;
  logic        rdy2, kv2, a4_en2;
  logic [23:0] key2, a4_key2;
  logic [7:0]  pt_addr2;
  logic        a4_rdy;
  logic [7:0]  pt_rddata;

  arc4_key_search #(.KEY_START(24'h000000), .KEY_LAST(24'h000005)) dut (
    .clk(clk), .rst(rst), .en(en), .rdy(rdy1), .key(key1), .key_valid(kv1),
    .a4_en(a4_en1), .a4_rdy(a4_rdy), .a4_key(a4_key1),
    .pt_addr(pt_addr1), .pt_rddata(pt_rddata)
  );

  arc4_key_search #(.KEY_START(24'hFFFFFE), .KEY_LAST(24'hFFFFFE)) dut2 (
    .clk(clk), .rst(rst), .en(en2), .rdy(rdy2), .key(key2), .key_valid(kv2),
    .a4_en(a4_en2), .a4_rdy(a4_rdy), .a4_key(a4_key2),
    .pt_addr(pt_addr2), .pt_rddata(pt_rddata)
  );

  // Models serve whichever DUT is selected
  logic        m_a4_en, m_rdy_out;
  logic [23:0] m_a4_key;
  logic [7:0]  m_pt_addr;
  assign m_a4_en   = sel ? a4_en2   : a4_en1;
  assign m_a4_key  = sel ? a4_key2  : a4_key1;
  assign m_pt_addr = sel ? pt_addr2 : pt_addr1;
  assign m_rdy_out = sel ? rdy2     : rdy1;

  logic        m_rdy = 1'b1;
  logic [23:0] m_key = '0;
  logic [7:0]  prev_addr = '0;
  int          busy_cnt = 0;
  int          cyc = 0;
  int          hold_until = 0;
  int          pt_mode = 0;
  int          en_busy_cnt = 0;
  logic [7:0]  mem [256];
  int          visit [256];

  assign a4_rdy = m_rdy && (cyc >= hold_until);

  // Scripted plaintext for a given mode/key/address
  function automatic logic [7:0] pt_byte(input int mode, input logic [23:0] k, input int idx);
    case (mode)
      0: begin
        case (idx)
          0: return 8'h03;
          1: return 8'h41;
          2: return (k == 24'd3) ? 8'h42 : 8'h01;
          3: return 8'h43;
          default: return 8'h20;
        endcase
      end
      1: return 8'h7F;
      2: return 8'h00;
      default: return (idx == 0) ? 8'hFF : (idx[0] ? 8'h20 : 8'h7E);
    endcase
  endfunction

  // arc4 responder, plaintext RAM and address-visit tracker
  always @(posedge clk) begin
    cyc       <= cyc + 1;
    pt_rddata <= mem[m_pt_addr];
    if (m_a4_en && !a4_rdy) en_busy_cnt <= en_busy_cnt + 1;
    if (m_a4_en && a4_rdy) begin
      m_rdy    <= 1'b0;
      busy_cnt <= 40;
      m_key    <= m_a4_key;
    end else if (!m_rdy) begin
      if (busy_cnt == 1) begin
        for (int i = 0; i < 256; i++) mem[i] <= pt_byte(pt_mode, m_key, i);
        m_rdy <= 1'b1;
      end
      busy_cnt <= busy_cnt - 1;
    end
    if (m_pt_addr != prev_addr && m_pt_addr != 8'd0) visit[m_pt_addr] <= visit[m_pt_addr] + 1;
    prev_addr <= m_pt_addr;
  end

  int          errors = 0;
  int          checks = 0;
  logic [23:0] exp_q [$];
  logic [23:0] obs_q [$];

  // Collect a4_en pulses until the selected DUT reports ready
  task automatic run_search(input int budget, output int pulses, output bit timeout);
    pulses  = 0;
    timeout = 1'b1;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (m_a4_en) begin
        obs_q.push_back(m_a4_key);
        pulses++;
      end
      if (m_rdy_out) begin
        timeout = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++; if (rdy1 !== 1'b1) begin errors++; $display("FAIL reset_rdy: got %b want 1", rdy1); end
    checks++; if (kv1 !== 1'b0) begin errors++; $display("FAIL reset_key_valid: got %b want 0", kv1); end
    checks++; if (key1 !== 24'h0) begin errors++; $display("FAIL reset_key: got %h want 000000", key1); end
    checks++; if (a4_en1 !== 1'b0) begin errors++; $display("FAIL reset_a4_en: got %b want 0", a4_en1); end
    checks++; if (a4_key1 !== 24'h0) begin errors++; $display("FAIL reset_a4_key: got %h want 000000", a4_key1); end
    checks++; if (pt_addr1 !== 8'h0) begin errors++; $display("FAIL reset_pt_addr: got %h want 00", pt_addr1); end
    checks++; if (a4_key2 !== 24'hFFFFFE) begin errors++; $display("FAIL reset_a4_key2: got %h want fffffe", a4_key2); end
    rst = 1'b0;
  endtask

  task automatic test_wait_ready();
    int  first_cyc, pulses;
    bit  width_ok, to;
    logic [23:0] got;
    @(negedge clk);
    rst = 1'b1;
    hold_until = cyc + 10;
    pt_mode = 2;
    obs_q.delete(); exp_q.delete();
    for (int k = 0; k <= 5; k++) exp_q.push_back(24'(k));
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    @(negedge clk); en = 1'b1;
    @(negedge clk); en = 1'b0;
    first_cyc = -1; width_ok = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (a4_en1) begin
        first_cyc = cyc;
        obs_q.push_back(a4_key1);
        @(negedge clk);
        width_ok = !a4_en1;
        break;
      end
    end
    checks++; if (first_cyc <= hold_until) begin errors++; $display("FAIL hold_a4_en_early: pulse at cycle %0d, hold ends %0d", first_cyc, hold_until); end
    checks++; if (!width_ok) begin errors++; $display("FAIL hold_a4_en_width: got multi-cycle pulse want 1 cycle"); end
    run_search(2000, pulses, to);
    checks++; if (to) begin errors++; $display("FAIL empty_msg_timeout: rdy %b want 1", rdy1); end
    checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL empty_msg_trials: got %0d want %0d", obs_q.size(), exp_q.size()); end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      got = obs_q.pop_front();
      checks++; if (got !== exp_q[0]) begin errors++; $display("FAIL empty_msg_key: got %h want %h", got, exp_q[0]); end
      void'(exp_q.pop_front());
    end
    checks++; if (kv1 !== 1'b0) begin errors++; $display("FAIL empty_msg_key_valid: got %b want 0", kv1); end
    checks++; if (en_busy_cnt != 0) begin errors++; $display("FAIL a4_en_into_busy: got %0d want 0", en_busy_cnt); end
  endtask

  task automatic test_search_pass();
    int pulses; bit to; logic [23:0] got;
    pt_mode = 0;
    obs_q.delete(); exp_q.delete();
    for (int k = 0; k <= 3; k++) exp_q.push_back(24'(k));
    @(negedge clk); en = 1'b1;
    @(negedge clk); en = 1'b0;
    run_search(2000, pulses, to);
    checks++; if (to) begin errors++; $display("FAIL pass_timeout: rdy %b want 1", rdy1); end
    checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL pass_trials: got %0d want %0d", obs_q.size(), exp_q.size()); end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      got = obs_q.pop_front();
      checks++; if (got !== exp_q[0]) begin errors++; $display("FAIL pass_a4_key: got %h want %h", got, exp_q[0]); end
      void'(exp_q.pop_front());
    end
    checks++; if (key1 !== 24'd3) begin errors++; $display("FAIL pass_key: got %h want 000003", key1); end
    checks++; if (kv1 !== 1'b1) begin errors++; $display("FAIL pass_key_valid: got %b want 1", kv1); end
  endtask

  task automatic test_exhaust();
    int pulses; bit to; logic [23:0] got;
    sel = 1'b1;
    pt_mode = 1;
    obs_q.delete(); exp_q.delete();
    exp_q.push_back(24'hFFFFFE);
    @(negedge clk); en2 = 1'b1;
    @(negedge clk); en2 = 1'b0;
    run_search(2000, pulses, to);
    checks++; if (to) begin errors++; $display("FAIL exhaust_timeout: rdy %b want 1", rdy2); end
    checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL exhaust_trials: got %0d want %0d", obs_q.size(), exp_q.size()); end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      got = obs_q.pop_front();
      checks++; if (got !== exp_q[0]) begin errors++; $display("FAIL exhaust_a4_key: got %h want %h", got, exp_q[0]); end
      void'(exp_q.pop_front());
    end
    checks++; if (kv2 !== 1'b0) begin errors++; $display("FAIL exhaust_key_valid: got %b want 0", kv2); end
    checks++; if (a4_key2 !== 24'hFFFFFE) begin errors++; $display("FAIL exhaust_no_wrap: got %h want fffffe", a4_key2); end
    @(negedge clk);
    sel = 1'b0;
  endtask

  task automatic test_max_len();
    int pulses, bad; bit to; logic [23:0] got;
    int base [256];
    pt_mode = 3;
    obs_q.delete(); exp_q.delete();
    exp_q.push_back(24'h0);
    @(negedge clk);
    for (int a = 0; a < 256; a++) base[a] = visit[a];
    en = 1'b1;
    @(negedge clk); en = 1'b0;
    run_search(3000, pulses, to);
    checks++; if (to) begin errors++; $display("FAIL maxlen_timeout: rdy %b want 1", rdy1); end
    checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL maxlen_trials: got %0d want %0d", obs_q.size(), exp_q.size()); end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      got = obs_q.pop_front();
      checks++; if (got !== exp_q[0]) begin errors++; $display("FAIL maxlen_a4_key: got %h want %h", got, exp_q[0]); end
      void'(exp_q.pop_front());
    end
    bad = 0;
    for (int a = 1; a < 256; a++) if (visit[a] - base[a] != 1) bad++;
    checks++; if (bad != 0) begin errors++; $display("FAIL maxlen_addr_visits: %0d addresses not read exactly once, want 0", bad); end
    checks++; if (kv1 !== 1'b1) begin errors++; $display("FAIL maxlen_key_valid: got %b want 1", kv1); end
    checks++; if (key1 !== 24'h0) begin errors++; $display("FAIL maxlen_key: got %h want 000000", key1); end
  endtask

  task automatic test_en_held();
    int pulses; bit to; logic [23:0] got;
    pt_mode = 0;
    obs_q.delete(); exp_q.delete();
    for (int k = 0; k <= 3; k++) exp_q.push_back(24'(k));
    @(negedge clk); en = 1'b1;
    @(negedge clk);
    run_search(2000, pulses, to);
    checks++; if (to) begin errors++; $display("FAIL held_timeout: rdy %b want 1", rdy1); end
    checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL held_trials: got %0d want %0d", obs_q.size(), exp_q.size()); end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      got = obs_q.pop_front();
      checks++; if (got !== exp_q[0]) begin errors++; $display("FAIL held_a4_key: got %h want %h", got, exp_q[0]); end
      void'(exp_q.pop_front());
    end
    checks++; if (kv1 !== 1'b1 || key1 !== 24'd3) begin errors++; $display("FAIL held_result: key %h valid %b want 000003 1", key1, kv1); end
    @(negedge clk);
    checks++; if (rdy1 !== 1'b0 || kv1 !== 1'b0) begin errors++; $display("FAIL held_restart: rdy %b valid %b want 0 0", rdy1, kv1); end
    en = 1'b0;
    obs_q.delete(); exp_q.delete();
    for (int k = 0; k <= 3; k++) exp_q.push_back(24'(k));
    run_search(2000, pulses, to);
    checks++; if (to || pulses != 4) begin errors++; $display("FAIL held_second_search: pulses %0d timeout %b want 4 0", pulses, to); end
    checks++; if (kv1 !== 1'b1) begin errors++; $display("FAIL held_second_valid: got %b want 1", kv1); end
  endtask

  task automatic test_mid_reset();
    int pulses; bit to, reached; logic [23:0] got;
    pt_mode = 3;
    @(negedge clk); en = 1'b1;
    @(negedge clk); en = 1'b0;
    reached = 1'b0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (pt_addr1 >= 8'd10) begin reached = 1'b1; break; end
    end
    checks++; if (!reached) begin errors++; $display("FAIL midrst_scan_timeout: pt_addr %h want >= 0a", pt_addr1); end
    rst = 1'b1;
    #1;
    checks++; if (rdy1 !== 1'b1 || kv1 !== 1'b0 || a4_en1 !== 1'b0) begin
      errors++; $display("FAIL midrst_async: rdy %b valid %b a4_en %b want 1 0 0", rdy1, kv1, a4_en1);
    end
    checks++; if (pt_addr1 !== 8'h0 || a4_key1 !== 24'h0) begin
      errors++; $display("FAIL midrst_addr_key: pt_addr %h a4_key %h want 00 000000", pt_addr1, a4_key1);
    end
    @(negedge clk); rst = 1'b0;
    obs_q.delete(); exp_q.delete();
    exp_q.push_back(24'h0);
    @(negedge clk); en = 1'b1;
    @(negedge clk); en = 1'b0;
    run_search(3000, pulses, to);
    checks++; if (to) begin errors++; $display("FAIL midrst_timeout: rdy %b want 1", rdy1); end
    checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL midrst_trials: got %0d want %0d", obs_q.size(), exp_q.size()); end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      got = obs_q.pop_front();
      checks++; if (got !== exp_q[0]) begin errors++; $display("FAIL midrst_a4_key: got %h want %h", got, exp_q[0]); end
      void'(exp_q.pop_front());
    end
    checks++; if (kv1 !== 1'b1 || key1 !== 24'h0) begin errors++; $display("FAIL midrst_result: key %h valid %b want 000000 1", key1, kv1); end
    checks++; if (en_busy_cnt != 0) begin errors++; $display("FAIL midrst_en_into_busy: got %0d want 0", en_busy_cnt); end
  endtask

  initial begin
    test_reset();
    test_wait_ready();
    test_search_pass();
    test_exhaust();
    test_max_len();
    test_en_held();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
